// File: rtl/gate_check_pkg.sv
// gate_check_pkg: sequencer state type, vector count and expected NAND response
package gate_check_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} gc_state_t;
  localparam int GC_NUM_VECTORS = 4;
  function automatic logic gc_expected(input logic a, input logic b);
    return ~(a & b);
  endfunction
endpackage

// File: rtl/gate_check_hold_timer.sv
// gate_check_hold_timer: counts HOLD_CYCLES per vector while en, flags last cycle, wraps to 0
module gate_check_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] END_V = W'(HOLD_CYCLES - 1);
  logic [W-1:0] cnt;
  assign last = en && cnt == END_V;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gate_check_sequencer.sv
// gate_check_sequencer: drives 4 NAND vectors, samples y, counts mismatches (GATE_CHECK_STOP_ON_FAIL_EN: stop at first miss)
module gate_check_sequencer
  import gate_check_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt
);
  localparam logic [1:0] VEC_LAST = 2'(GC_NUM_VECTORS - 1);
  gc_state_t state;
  logic last, miss, fin;
  logic [1:0] idx_nxt;
  logic [2:0] err_nxt;
  gate_check_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   (state == DRIVE),
    .last (last)
  );
  assign miss    = y != gc_expected(a, b);
  assign err_nxt = err_cnt + {2'b00, miss};
  assign idx_nxt = vec_idx + 2'd1;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  assign fin = last && (miss || vec_idx == VEC_LAST);
`else
  assign fin = last && vec_idx == VEC_LAST;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      a       <= 1'b0;
      b       <= 1'b0;
      vec_idx <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= DRIVE;
            a       <= 1'b0;
            b       <= 1'b0;
            vec_idx <= 2'd0;
            busy    <= 1'b1;
            pass    <= 1'b0;
            err_cnt <= 3'd0;
          end
        end
        DRIVE: begin
          if (last) err_cnt <= err_nxt;
          if (fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= err_nxt == 3'd0;
          end else if (last) begin
            vec_idx <= idx_nxt;
            a       <= idx_nxt[1];
            b       <= idx_nxt[0];
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_gate_check_sequencer.sv
// tb_gate_check_sequencer: randomized and directed passes on H=4/1/2 instances against a truth-table gate model
module tb_gate_check_sequencer;
  localparam int HS [3] = '{4, 1, 2};
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic st [3];
  logic [3:0] tt [3];
  logic a_o [3], b_o [3], busy_o [3], done_o [3], pass_o [3], y_i [3];
  logic [1:0] vi_o [3];
  logic [2:0] ec_o [3];
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign y_i[g] = tt[g][{a_o[g], b_o[g]}];
    gate_check_sequencer #(.HOLD_CYCLES(HS[g])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (st[g]),
      .y       (y_i[g]),
      .a       (a_o[g]),
      .b       (b_o[g]),
      .vec_idx (vi_o[g]),
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .pass    (pass_o[g]),
      .err_cnt (ec_o[g])
    );
  end
  task automatic run_pass(input int i, input logic [3:0] t, input int re);
    int h, lk, ne, nn, k, pulses;
    bit stopped;
    logic [3:0] mm;
    logic [1:0] v;
    logic [2:0] pre;
    logic [8:0] obs, exp;
    h = HS[i];
    tt[i] = t;
    lk = 3;
    ne = 0;
    stopped = 1'b0;
    for (int j = 0; j < 4; j++) begin
      v = 2'(j);
      mm[j] = t[j] != ~(v[1] & v[0]);
      if (!stopped) begin
        if (mm[j]) ne++;
        if (STOP && mm[j]) begin
          lk = j;
          stopped = 1'b1;
        end
      end
    end
    nn = (lk + 1) * h;
    @(negedge clk) st[i] = 1'b1;
    @(negedge clk) st[i] = 1'b0;
    for (int n = 1; n <= nn; n++) begin
      k = (n - 1) / h;
      v = 2'(k);
      pre = 3'd0;
      for (int j = 0; j < k; j++) pre += {2'b00, mm[j]};
      exp = {v[1], v[0], v, 1'b1, 1'b0, pre};
      obs = {a_o[i], b_o[i], vi_o[i], busy_o[i], done_o[i], ec_o[i]};
      checks++;
      if (obs !== exp) $display("FAIL drive dut%0d t=%b cyc%0d {a,b,idx,busy,done,err} got %b want %b", i, t, n, obs, exp);
      else passes++;
      if (n == re) st[i] = 1'b1;
      if (n == re + 1) st[i] = 1'b0;
      @(negedge clk);
    end
    st[i] = 1'b0;
    v = 2'(lk);
    exp = {v[1], v[0], v, 1'b0, 1'b1, 3'(ne)};
    obs = {a_o[i], b_o[i], vi_o[i], busy_o[i], done_o[i], ec_o[i]};
    checks++;
    if (obs !== exp || pass_o[i] !== (ne == 0)) $display("FAIL done dut%0d t=%b {a,b,idx,busy,done,err} got %b want %b pass got %b want %b", i, t, obs, exp, pass_o[i], ne == 0);
    else passes++;
    pulses = 0;
    for (int c = 0; c < 2 * h + 3; c++) begin
      @(negedge clk);
      if (done_o[i]) pulses++;
    end
    exp = {v[1], v[0], v, 1'b0, 1'b0, 3'(ne)};
    obs = {a_o[i], b_o[i], vi_o[i], busy_o[i], done_o[i], ec_o[i]};
    checks++;
    if (obs !== exp || pass_o[i] !== (ne == 0) || pulses != 0) $display("FAIL hold dut%0d t=%b {a,b,idx,busy,done,err} got %b want %b pass %b extra_done %0d", i, t, obs, exp, pass_o[i], pulses);
    else passes++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_o[i], b_o[i], vi_o[i], busy_o[i], done_o[i], pass_o[i], ec_o[i]} !== 10'd0)
        $display("FAIL reset dut%0d got %b want 0", i, {a_o[i], b_o[i], vi_o[i], busy_o[i], done_o[i], pass_o[i], ec_o[i]});
      else passes++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_nand();
    run_pass(0, 4'b0111, 0);
  endtask
  task automatic test_and();
    run_pass(0, 4'b1000, 0);
  endtask
  task automatic test_stuck1_h1();
    run_pass(1, 4'b1111, 0);
  endtask
  task automatic test_restart();
    run_pass(0, 4'b0111, 6);
  endtask
  task automatic test_reset_mid();
    tt[0] = 4'b0111;
    @(negedge clk) st[0] = 1'b1;
    @(negedge clk) st[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_o[0], b_o[0], vi_o[0], busy_o[0], done_o[0], pass_o[0], ec_o[0]} !== 10'd0)
      $display("FAIL midreset got %b want 0", {a_o[0], b_o[0], vi_o[0], busy_o[0], done_o[0], pass_o[0], ec_o[0]});
    else passes++;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) $display("FAIL midreset_idle done %b busy %b want 0 0", done_o[0], busy_o[0]);
    else passes++;
    run_pass(0, 4'b0111, 0);
  endtask
  task automatic test_stuck0_h2();
    run_pass(2, 4'b0000, 0);
  endtask
  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_pass($urandom_range(0, 2), 4'($urandom), 0);
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      tt[i] = 4'b0111;
    end
    test_reset();
    test_nand();
    test_and();
    test_stuck1_h1();
    test_restart();
    test_reset_mid();
    test_stuck0_h2();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gate_check_sequencer.md
# gate_check_sequencer

- Self-checking stimulus controller for the two-input De Morgan gate datapath (`a`, `b` → `y`, with `y = ~(a & b)`).
- On `start`, it walks all four input vectors in order, drives each to the gate for a programmable hold time, and samples `y` at the end of the hold.
- It compares each sample against the expected value, counts mismatches, and reports `pass` and `done`.
- It replaces free-running toggle stimulus with a clocked, repeatable sequence usable on the lab board.

## Interface
- `HOLD_CYCLES`, default 4: clock cycles each vector is driven before sampling. Legal range is 1 to 255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle request to begin a check pass. Honoured only in IDLE.
- `y`  in  1  gate output under check.
- `a`  out  1  gate input A; equals `vec_idx[1]`.
- `b`  out  1  gate input B; equals `vec_idx[0]`.
- `vec_idx`  out  2  index of the vector currently driven, or the last vector checked.
- `busy`  out  1  high while in DRIVE.
- `done`  out  1  one-cycle pulse when a pass completes.
- `pass`  out  1  high when the last completed pass had `err_cnt == 0`.
- `err_cnt`  out  3  mismatches in the current or last pass (0 to 4).

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE → DRIVE** when `start` is high.
  - Load `vec_idx = 0` and `hold_cnt = 0`.
  - Clear `err_cnt`.
  - Clear `pass`.
- **DRIVE:**
  - `a` and `b` are registered from `vec_idx`.
  - `hold_cnt` increments every cycle.
  - When `hold_cnt == HOLD_CYCLES-1`, sample `y` on that edge:
    - Compare against `~(a & b)`.
    - On a mismatch, increment `err_cnt`.
    - Reset `hold_cnt` to 0.
    - If `vec_idx == 3`, go to DONE; otherwise increment `vec_idx`.
- **DONE** lasts exactly one cycle:
  - `done = 1`.
  - `pass = (err_cnt == 0)`.
  - Next state is IDLE.
- **Holds after a pass:** `pass`, `err_cnt`, and `vec_idx` hold their values until the next accepted `start`. `a` and `b` keep the last vector (1, 1).
- **Ignored start:** `start` while in DRIVE or DONE is ignored. It is not queued.
- **No saturation logic:** 3 bits hold the maximum count of 4.

## Timing
- Reset values: `a = 0`, `b = 0`, `vec_idx = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_cnt = 0`. State resets to IDLE and `hold_cnt` to 0.
- Cycle-level sequence, with `start` sampled at edge E0:
  - Vector 0 is visible on `a`/`b` after E0.
  - Vector k is driven during cycles k·H+1 through (k+1)·H, where H = `HOLD_CYCLES`.
  - Its sample is taken at edge E((k+1)·H).
- `done` is high for the single cycle following edge E(4H). With H=4, that is the cycle after E16.
- `y` must settle within H cycles minus setup. H=1 samples one cycle after drive.
- `err_cnt` updates on the sample edge and is visible in the next cycle.
- Reset asserted mid-DRIVE immediately returns all outputs to their reset values. No `done` is issued for the aborted pass.

## Configuration
- Macro: `GATE_CHECK_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch ends the pass.
  - The next state is DONE on the sample edge.
  - `err_cnt = 1`.
  - `vec_idx` holds the failing index.
  - `a`/`b` hold the failing vector.
  - `pass = 0`.
- **Undefined:** all four vectors are always checked and mismatches are accumulated.

## Structure
- Package `gate_check_pkg` contains:
  - State enum `gc_state_t` (IDLE, DRIVE, DONE).
  - Constant `GC_NUM_VECTORS = 4`.
  - Function `gc_expected(a, b)` returning `~(a & b)`.
- Sub-module `gate_check_hold_timer`:
  - Counter with parameter `HOLD_CYCLES`.
  - Inputs `clk`, `rst`, `clr`, `en`; output `last`.
  - Counter width is `$clog2(HOLD_CYCLES+1)`.
- The top module contains the FSM, vector index, error counter, and output registers.

## Test plan
- **Correct gate (NAND model), H=4:**
  - Pulse `start`.
  - `a`/`b` step through 00, 01, 10, 11, four cycles each.
  - `done` pulses in the cycle after E16.
  - `pass = 1`, `err_cnt = 0`.
- **Wrong gate (AND model), H=4:** `err_cnt = 4`, `pass = 0`, `done` timing identical to the correct-gate case.
- **`y` stuck at 1, H=1:** mismatch only on vector 3; `err_cnt = 1`, `pass = 0`, `done` in the cycle after E4.
- **`start` re-pulsed at E6 during a pass:** the sequence is unaffected; exactly one `done` pulse occurs.
- **Reset asserted at cycle 9 of a pass:** all outputs return to reset values. A following `start` produces a clean full pass with `pass = 1`.
- **With `GATE_CHECK_STOP_ON_FAIL_EN`, `y` stuck at 0, H=2:**
  - Vector 0 fails at E2.
  - `done` pulses in the following cycle.
  - `vec_idx = 0`, `err_cnt = 1`.
